// File: rtl/uart_slot_master_if.sv
// ============================================================================
//  Module      : uart_slot_master_if
//  Description : Slot register bus plus local tx/rx byte streams and baud
//                reprogramming controls of the UART slot master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_slot_master_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        baud_load;
  logic [13:0] baud_dvsr;
  logic        init_done;

  modport master (
    output cs, read, write, addr, wr_data, tx_ready, rx_valid, rx_byte, init_done,
    input  rd_data, tx_valid, tx_byte, rx_ready, baud_load, baud_dvsr
  );

  modport slave (
    input  cs, read, write, addr, wr_data, tx_ready, rx_valid, rx_byte, init_done,
    output rd_data, tx_valid, tx_byte, rx_ready, baud_load, baud_dvsr
  );
endinterface

`default_nettype wire

// File: rtl/uart_slot_master.sv
// ============================================================================
//  Module      : uart_slot_master
//  Description : Bus initiator for a UART slot: boot baud write, status poll,
//                rx pops and tx pushes behind valid/ready byte streams.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_slot_master #(
  parameter logic [13:0] BAUD_DVSR = 14'd325,
  parameter int unsigned POLL_GAP  = 0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  uart_slot_master_if.master   bus
);

  localparam logic [2:0] S_BOOT    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_POLL    = 3'd2;
  localparam logic [2:0] S_BAUD_WR = 3'd3;
  localparam logic [2:0] S_RX_POP  = 3'd4;
  localparam logic [2:0] S_TX_WR   = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [7:0] c_GAP_CYC  = 8'(POLL_GAP);
  localparam logic [7:0] c_GAP_LAST = c_GAP_CYC - 8'd1;
  localparam logic [2:0] c_IDLE_NXT = (POLL_GAP == 0) ? S_POLL : S_GAP;

  localparam logic [4:0] c_A_STAT = 5'd0;
  localparam logic [4:0] c_A_BAUD = 5'd1;
  localparam logic [4:0] c_A_TX   = 5'd2;
  localparam logic [4:0] c_A_POP  = 5'd3;

  logic [2:0]  r_state;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_tx_hold;
  logic        r_tx_hold_valid;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;
  logic [13:0] r_dvsr;
  logic        r_baud_pend;
  logic        r_init_done;

  logic [2:0]  w_next_state;
  logic        w_rx_empty;
  logic        w_tx_full;
  logic        w_pop;
  logic        w_tx_go;

  assign w_rx_empty = bus.rd_data[9];
  assign w_tx_full  = bus.rd_data[10];
  assign w_pop      = (r_state == S_POLL) && !r_baud_pend && !w_rx_empty && !r_rx_valid;
  assign w_tx_go    = r_tx_hold_valid && !w_tx_full;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:    w_next_state = S_INIT;
      S_INIT,
      S_BAUD_WR,
      S_RX_POP,
      S_TX_WR:   w_next_state = c_IDLE_NXT;
      S_POLL: begin
        // Priority: baud reprogram, then rx pop, then tx push.
        if (r_baud_pend)  w_next_state = S_BAUD_WR;
        else if (w_pop)   w_next_state = S_RX_POP;
        else if (w_tx_go) w_next_state = S_TX_WR;
        else              w_next_state = c_IDLE_NXT;
      end
      S_GAP:     if (r_gap_cnt == 8'd0) w_next_state = S_POLL;
      default:   w_next_state = S_BOOT;
    endcase
  end

  // Bus strobes are decoded straight from the state so reset idles them at once.
  always_comb begin
    bus.cs      = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = c_A_STAT;
    bus.wr_data = 32'd0;
    case (r_state)
      S_INIT: begin
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = c_A_BAUD;
        bus.wr_data = {18'd0, BAUD_DVSR};
      end
      S_POLL: begin
        bus.cs      = 1'b1;
        bus.read    = 1'b1;
      end
      S_BAUD_WR: begin
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = c_A_BAUD;
        bus.wr_data = {18'd0, r_dvsr};
      end
      S_RX_POP: begin
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = c_A_POP;
      end
      S_TX_WR: begin
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = c_A_TX;
        bus.wr_data = {24'd0, r_tx_hold};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_BOOT;
      r_gap_cnt       <= 8'd0;
      r_tx_hold       <= 8'd0;
      r_tx_hold_valid <= 1'b0;
      r_rx_byte       <= 8'd0;
      r_rx_valid      <= 1'b0;
      r_dvsr          <= 14'd0;
      r_baud_pend     <= 1'b0;
      r_init_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state == S_GAP && r_state != S_GAP)
        r_gap_cnt <= c_GAP_LAST;
      else if (r_state == S_GAP)
        r_gap_cnt <= r_gap_cnt - 8'd1;

      if (r_state == S_INIT)
        r_init_done <= 1'b1;

      if (r_state == S_TX_WR) begin
        r_tx_hold_valid <= 1'b0;
      end else if (bus.tx_valid && !r_tx_hold_valid) begin
        r_tx_hold       <= bus.tx_byte;
        r_tx_hold_valid <= 1'b1;
      end

      if (w_pop) begin
        r_rx_byte  <= bus.rd_data[7:0];
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // A load arriving during BAUD_WR keeps the request pending for another write.
      if (bus.baud_load) begin
        r_dvsr      <= bus.baud_dvsr;
        r_baud_pend <= 1'b1;
      end else if (r_state == S_BAUD_WR) begin
        r_baud_pend <= 1'b0;
      end
    end
  end

  assign bus.tx_ready  = !r_tx_hold_valid;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_byte   = r_rx_byte;
  assign bus.init_done = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_slot_master.sv
// ============================================================================
//  Module      : tb_uart_slot_master
//  Description : Scoreboard bench for uart_slot_master with a small slot model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_slot_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_slot_master_if if0 ();
  uart_slot_master_if if1 ();

  uart_slot_master #(.BAUD_DVSR(14'd325), .POLL_GAP(0)) u0 (
    .clk(clk), .reset(reset), .bus(if0.master)
  );
  uart_slot_master #(.BAUD_DVSR(14'd325), .POLL_GAP(2)) u1 (
    .clk(clk), .reset(reset), .bus(if1.master)
  );

  // Slot model: small rx FIFO and a tx_full flag
  logic [7:0] srx_mem [0:15];
  logic [7:0] srx_wp = 8'd0;
  logic [7:0] srx_rp = 8'd0;
  logic       tx_full = 1'b0;

  assign if0.rd_data = {21'd0, tx_full, (srx_wp == srx_rp), 1'b0, srx_mem[srx_rp[3:0]]};
  assign if1.rd_data = 32'h0000_0200;

  always @(posedge clk)
    if (reset && if0.cs && if0.write && if0.addr == 5'd3 && srx_rp != srx_wp)
      srx_rp <= srx_rp + 8'd1;

  logic [36:0] exp_wr [$];
  logic [7:0]  exp_rx [$];
  int total = 0;
  int bad = 0;
  int wr_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int kind(input logic cs, input logic rd, input logic wr);
    if (!cs) return 0;
    if (wr)  return 1;
    if (rd)  return 2;
    return 3;
  endfunction

  // Monitor: checks every bus write and rx handshake against the queues
  logic first_wr = 1'b1;
  logic prev_read = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      first_wr  <= 1'b1;
      prev_read <= 1'b0;
    end else begin
      if (if0.cs)
        chk("bus_legal", {60'd0, (if0.read ^ if0.write), if0.addr[4:2]}, 64'h8);
      if (if0.cs && if0.write) begin
        wr_count <= wr_count + 1;
        if (!first_wr)
          chk("poll_before_write", {63'd0, prev_read}, 64'd1);
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", if0.addr, if0.wr_data);
        end else begin
          chk("write", {27'd0, if0.addr, if0.wr_data}, {27'd0, exp_wr.pop_front()});
        end
        first_wr <= 1'b0;
      end
      prev_read <= if0.cs && if0.read;
      if (if0.rx_valid && if0.rx_ready) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rx: got %0h expected none", if0.rx_byte);
        end else begin
          chk("rx_byte", {56'd0, if0.rx_byte}, {56'd0, exp_rx.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot_push(input logic [7:0] b);
    srx_mem[srx_wp[3:0]] = b;
    srx_wp = srx_wp + 8'd1;
  endtask

  task automatic send_tx(input logic [7:0] b, input logic push);
    int n;
    logic acc;
    if (push) exp_wr.push_back({5'd2, 24'd0, b});
    if0.tx_valid = 1'b1;
    if0.tx_byte  = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = if0.tx_ready;
      tick();
      n++;
    end
    if0.tx_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL tx_accept_timeout: got no accept expected accept of %0h", b);
    end else begin
      @(negedge clk);
      chk("tx_ready_held", {63'd0, if0.tx_ready}, 64'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({name, "_rx_left"}, 64'(exp_rx.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0 [8];
    int e1 [8];
    int r6 [3];
    int w0;
    int n;
    logic seen;
    e0 = '{0, 1, 2, 2, 2, 2, 2, 2};
    e1 = '{0, 1, 0, 0, 2, 0, 0, 2};
    r6 = '{0, 1, 2};
    for (int i = 0; i < 16; i++) srx_mem[i] = 8'h00;
    if0.tx_valid = 1'b0; if0.tx_byte = 8'h00; if0.rx_ready = 1'b0;
    if0.baud_load = 1'b0; if0.baud_dvsr = 14'd0;
    if1.tx_valid = 1'b0; if1.tx_byte = 8'h00; if1.rx_ready = 1'b0;
    if1.baud_load = 1'b0; if1.baud_dvsr = 14'd0;

    // T1: reset state and boot sequence
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", {27'd0, if0.cs, if0.read, if0.write, if0.addr, if0.wr_data}, 64'd0);
    chk("reset_flags", {53'd0, if0.init_done, if0.rx_valid, if0.rx_byte, if0.tx_ready}, 64'd1);
    exp_wr.push_back({5'd1, 32'h0000_0145});
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("boot_gap0_c%0d", k + 1), 64'(kind(if0.cs, if0.read, if0.write)), 64'(e0[k]));
      chk($sformatf("boot_gap2_c%0d", k + 1), 64'(kind(if1.cs, if1.read, if1.write)), 64'(e1[k]));
      if (k == 0) chk("init_done_c1", {63'd0, if0.init_done}, 64'd0);
      if (k == 2) begin
        chk("init_done_c3", {63'd0, if0.init_done}, 64'd1);
        chk("poll_addr_c3", {59'd0, if0.addr}, 64'd0);
      end
      if (k == 1) chk("gap2_init_data", {32'd0, if1.wr_data}, 64'h145);
    end

    // T2: rx pop with back-pressure
    tick();
    w0 = wr_count;
    slot_push(8'h5A);
    slot_push(8'h6B);
    exp_wr.push_back({5'd3, 32'd0});
    exp_rx.push_back(8'h5A);
    repeat (12) tick();
    chk("rx_hold_valid", {63'd0, if0.rx_valid}, 64'd1);
    chk("rx_hold_byte", {56'd0, if0.rx_byte}, 64'h5A);
    chk("rx_backpressure_writes", 64'(wr_count - w0), 64'd1);
    exp_wr.push_back({5'd3, 32'd0});
    exp_rx.push_back(8'h6B);
    if0.rx_ready = 1'b1;
    wait_drain("t2");

    // T3: back-to-back tx bytes
    w0 = wr_count;
    send_tx(8'h11, 1'b1);
    send_tx(8'h22, 1'b1);
    send_tx(8'h33, 1'b1);
    wait_drain("t3");
    chk("t3_write_count", 64'(wr_count - w0), 64'd3);

    // T4: tx_full stalls the held byte
    tx_full = 1'b1;
    send_tx(8'h44, 1'b1);
    w0 = wr_count;
    repeat (8) tick();
    chk("txfull_only_polls", 64'(wr_count - w0), 64'd0);
    chk("txfull_still_held", {63'd0, if0.tx_ready}, 64'd0);
    tx_full = 1'b0;
    wait_drain("t4");

    // T5: baud, rx and tx all pending together
    tx_full = 1'b1;
    send_tx(8'h77, 1'b0);
    tick();
    if0.baud_load = 1'b1;
    if0.baud_dvsr = 14'h01B;
    tick();
    if0.baud_load = 1'b0;
    exp_wr.push_back({5'd1, 32'h0000_001B});
    exp_wr.push_back({5'd3, 32'd0});
    exp_wr.push_back({5'd2, 32'h0000_0077});
    exp_rx.push_back(8'h9C);
    slot_push(8'h9C);
    tx_full = 1'b0;
    wait_drain("t5");

    // T6: reset asserted during TX_WR
    send_tx(8'h88, 1'b1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (if0.cs && if0.write && if0.addr == 5'd2) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tx_wr_timeout: got no TX_WR expected TX_WR");
    end
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_bus", {61'd0, if0.cs, if0.read, if0.write}, 64'd0);
    chk("rst_mid_flags", {62'd0, if0.tx_ready, if0.init_done}, 64'd2);
    exp_wr.push_back({5'd1, 32'h0000_0145});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("reboot_c%0d", k + 1), 64'(kind(if0.cs, if0.read, if0.write)), 64'(r6[k]));
    end
    chk("reboot_init_done", {63'd0, if0.init_done}, 64'd1);
    wait_drain("t6");
    chk("t6_tx_lost", {63'd0, if0.tx_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
